// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: state encoding,
// header field layout and limits.
package router_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_PLD  = 3'd2,
      ST_PAR  = 3'd3,
      ST_CHK  = 3'd4
   } state_e;

   localparam int unsigned LEN_W        = 6;
   localparam int unsigned ADDR_W       = 2;
   localparam int unsigned HDR_W        = 8;
   localparam int unsigned HDR_LEN_MSB  = 7;
   localparam int unsigned HDR_LEN_LSB  = 2;
   localparam int unsigned HDR_ADDR_MSB = 1;
   localparam int unsigned HDR_ADDR_LSB = 0;
   localparam int unsigned PKT_MAX_LEN  = 63;

   localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

   // Build the header byte from payload length and destination port.
   function automatic logic [HDR_W-1:0] make_hdr(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
      logic [HDR_W-1:0] h;
      h = '0;
      h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
      h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
      return h;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload byte store: synchronous write, asynchronous indexed read.
module router_tx_buf
   import router_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = PKT_MAX_LEN
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [LEN_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [LEN_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data_c
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store one byte per write strobe; contents are not reset.
   always_ff @(posedge clock) begin
      if (wr_en && (32'(wr_addr) < DEPTH)) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Out-of-range reads (one past the last byte) return zero.
   assign rd_data_c = (32'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends header,
// payload bytes and an XOR parity byte under router backpressure.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MAX_LEN = PKT_MAX_LEN
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ld_en,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [1:0]        dest_addr,
   input  logic              start,
   input  logic              abort,
   input  logic              busy,
   input  logic              err,
   output logic              pkt_valid,
   output logic [DATA_W-1:0] data_in,
   output logic              tx_active,
   output logic              done,
   output logic              pkt_err,
   output logic              req_err,
   output logic              ld_ovf
);

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [LEN_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] parity_q, parity_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic              tx_active_q, tx_active_d;
   logic              done_q, done_d;
   logic              pkt_err_q, pkt_err_d;
   logic              req_err_q, req_err_d;
   logic              ld_ovf_q, ld_ovf_d;
   logic              chk_cnt_q, chk_cnt_d;

   logic              buf_we_c;
   logic [LEN_W-1:0]  rd_addr_c;
   logic [DATA_W-1:0] rd_data_c;
   logic              start_ok_c;
   logic              last_byte_c;
   logic [DATA_W-1:0] hdr_c;

   router_tx_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_LEN)
   ) u_buf (
      .clock     (clock),
      .wr_en     (buf_we_c),
      .wr_addr   (count_q),
      .wr_data   (ld_data),
      .rd_addr   (rd_addr_c),
      .rd_data_c (rd_data_c)
   );

   // Decode helpers: start acceptance, last payload byte, header and next read index.
   assign start_ok_c  = start && (count_q != '0) && (dest_addr != ADDR_INVALID);
   assign last_byte_c = (rd_ptr_q == (count_q - LEN_W'(1)));
   assign hdr_c       = DATA_W'(make_hdr(count_q, dest_addr));
   assign rd_addr_c   = (state_q == ST_HDR) ? '0 : (rd_ptr_q + LEN_W'(1));

   // State register and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         parity_q    <= '0;
         data_in_q   <= '0;
         pkt_valid_q <= 1'b0;
         tx_active_q <= 1'b0;
         done_q      <= 1'b0;
         pkt_err_q   <= 1'b0;
         req_err_q   <= 1'b0;
         ld_ovf_q    <= 1'b0;
         chk_cnt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         parity_q    <= parity_d;
         data_in_q   <= data_in_d;
         pkt_valid_q <= pkt_valid_d;
         tx_active_q <= tx_active_d;
         done_q      <= done_d;
         pkt_err_q   <= pkt_err_d;
         req_err_q   <= req_err_d;
         ld_ovf_q    <= ld_ovf_d;
         chk_cnt_q   <= chk_cnt_d;
      end
   end

   // Next-state and next-output logic; abort overrides everything.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      parity_d    = parity_q;
      data_in_d   = data_in_q;
      pkt_valid_d = pkt_valid_q;
      chk_cnt_d   = chk_cnt_q;
      done_d      = 1'b0;
      req_err_d   = 1'b0;
      pkt_err_d   = pkt_err_q;
      ld_ovf_d    = ld_ovf_q;
      buf_we_c    = 1'b0;

      if (abort) begin
         state_d     = ST_IDLE;
         count_d     = '0;
         rd_ptr_d    = '0;
         parity_d    = '0;
         data_in_d   = '0;
         pkt_valid_d = 1'b0;
         chk_cnt_d   = 1'b0;
         ld_ovf_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok_c) begin
                  state_d     = ST_HDR;
                  pkt_valid_d = 1'b1;
                  data_in_d   = hdr_c;
                  parity_d    = hdr_c;
                  rd_ptr_d    = '0;
                  pkt_err_d   = 1'b0;
                  ld_ovf_d    = 1'b0;
               end else begin
                  req_err_d = start;
                  if (ld_en) begin
                     if (count_q < MAX_CNT) begin
                        buf_we_c = 1'b1;
                        count_d  = count_q + LEN_W'(1);
                     end else begin
                        ld_ovf_d = 1'b1;
                     end
                  end
               end
            end
            ST_HDR: begin
               if (!busy) begin
                  state_d     = ST_PLD;
                  pkt_valid_d = 1'b1;
                  data_in_d   = rd_data_c;
               end
            end
            ST_PLD: begin
               if (!busy) begin
                  parity_d = parity_q ^ data_in_q;
                  if (last_byte_c) begin
                     state_d     = ST_PAR;
                     pkt_valid_d = 1'b0;
                     data_in_d   = parity_q ^ data_in_q;
                  end else begin
                     rd_ptr_d  = rd_ptr_q + LEN_W'(1);
                     data_in_d = rd_data_c;
                  end
               end
            end
            ST_PAR: begin
               if (!busy) begin
                  state_d     = ST_CHK;
                  pkt_valid_d = 1'b0;
                  data_in_d   = '0;
                  chk_cnt_d   = 1'b0;
               end
            end
            ST_CHK: begin
               if (err) begin
                  pkt_err_d = 1'b1;
               end
               if (chk_cnt_q) begin
                  state_d   = ST_IDLE;
                  done_d    = 1'b1;
                  count_d   = '0;
                  rd_ptr_d  = '0;
                  chk_cnt_d = 1'b0;
               end else begin
                  chk_cnt_d = 1'b1;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               pkt_valid_d = 1'b0;
               data_in_d   = '0;
               count_d     = '0;
               rd_ptr_d    = '0;
            end
         endcase
      end

      tx_active_d = (state_d != ST_IDLE);
   end

   assign pkt_valid = pkt_valid_q;
   assign data_in   = data_in_q;
   assign tx_active = tx_active_q;
   assign done      = done_q;
   assign pkt_err   = pkt_err_q;
   assign req_err   = req_err_q;
   assign ld_ovf    = ld_ovf_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: queue-based packet model checked every cycle,
// plus directed scenarios with hand-computed byte streams.
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       ld_en = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic [1:0] dest_addr = 2'd0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy = 1'b0;
   logic       err = 1'b0;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic       tx_active;
   logic       done;
   logic       pkt_err;
   logic       req_err;
   logic       ld_ovf;

   int checks = 0;
   int failures = 0;

   router_pkt_tx #(.DATA_W(8), .MAX_LEN(63)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .ld_en     (ld_en),
      .ld_data   (ld_data),
      .dest_addr (dest_addr),
      .start     (start),
      .abort     (abort),
      .busy      (busy),
      .err       (err),
      .pkt_valid (pkt_valid),
      .data_in   (data_in),
      .tx_active (tx_active),
      .done      (done),
      .pkt_err   (pkt_err),
      .req_err   (req_err),
      .ld_ovf    (ld_ovf)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A packet is a list of output words still to be shown; loaded bytes are a queue.
   typedef struct packed {
      logic       chk;
      logic       pv;
      logic [7:0] data;
   } ent_t;

   logic [7:0] m_buf[$];
   ent_t       m_seq[$];
   logic       m_pv = 1'b0, m_act = 1'b0, m_done = 1'b0;
   logic       m_perr = 1'b0, m_rerr = 1'b0, m_ovf = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic [7:0] m_h, m_p;

   task automatic model_reset();
      m_buf.delete();
      m_seq.delete();
      m_pv = 1'b0; m_act = 1'b0; m_done = 1'b0;
      m_perr = 1'b0; m_rerr = 1'b0; m_ovf = 1'b0;
      m_data = 8'h00;
   endtask

   task automatic model_step();
      m_done = 1'b0;
      m_rerr = 1'b0;
      if (abort) begin
         m_seq.delete();
         m_buf.delete();
         m_ovf = 1'b0;
      end else if (m_seq.size() == 0) begin
         if (start && m_buf.size() > 0 && dest_addr != 2'd3) begin
            m_h = {6'(m_buf.size()), dest_addr};
            m_p = m_h;
            m_seq.push_back({1'b0, 1'b1, m_h});
            foreach (m_buf[i]) begin
               m_seq.push_back({1'b0, 1'b1, m_buf[i]});
               m_p = m_p ^ m_buf[i];
            end
            m_seq.push_back({1'b0, 1'b0, m_p});
            m_seq.push_back({1'b1, 1'b0, 8'h00});
            m_seq.push_back({1'b1, 1'b0, 8'h00});
            m_perr = 1'b0;
            m_ovf  = 1'b0;
         end else begin
            if (start) m_rerr = 1'b1;
            if (ld_en) begin
               if (m_buf.size() < 63) m_buf.push_back(ld_data);
               else m_ovf = 1'b1;
            end
         end
      end else if (m_seq[0].chk) begin
         if (err) m_perr = 1'b1;
         void'(m_seq.pop_front());
         if (m_seq.size() == 0) begin
            m_done = 1'b1;
            m_buf.delete();
         end
      end else if (!busy) begin
         void'(m_seq.pop_front());
      end
      m_act = (m_seq.size() != 0);
      if (m_act) begin
         m_pv   = m_seq[0].pv;
         m_data = m_seq[0].data;
      end else begin
         m_pv   = 1'b0;
         m_data = 8'h00;
      end
   endtask

   // Model advances on the same edges as the design.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clock) begin
      if (reset_n) begin
         check("cmp_pkt_valid", 32'(pkt_valid), 32'(m_pv));
         check("cmp_data_in",   32'(data_in),   32'(m_data));
         check("cmp_tx_active", 32'(tx_active), 32'(m_act));
         check("cmp_done",      32'(done),      32'(m_done));
         check("cmp_pkt_err",   32'(pkt_err),   32'(m_perr));
         check("cmp_req_err",   32'(req_err),   32'(m_rerr));
         check("cmp_ld_ovf",    32'(ld_ovf),    32'(m_ovf));
      end
   end

   // ---------------- directed stimulus ----------------
   logic [8:0] lg[$];
   logic       done_seen;

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic load(input logic [7:0] b);
      ld_en = 1'b1;
      ld_data = b;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic pulse_start(input logic [1:0] d);
      start = 1'b1;
      dest_addr = d;
      tick();
      start = 1'b0;
   endtask

   // Log {pkt_valid,data_in} for every active cycle until the packet ends.
   task automatic run_pkt(input bit hold_en, input logic [7:0] hold_byte, input bit err2);
      int  busy_left = 0;
      int  quiet = 0;
      bit  held = 1'b0;
      bit  fin = 1'b0;
      lg.delete();
      done_seen = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
         if (!tx_active) begin
            done_seen = done;
            fin = 1'b1;
         end else begin
            lg.push_back({pkt_valid, data_in});
            if (hold_en && !held && pkt_valid && data_in == hold_byte) begin
               held = 1'b1;
               busy_left = 4;
            end
            busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (!pkt_valid) quiet++;
            err = err2 && (quiet == 3);
            tick();
         end
      end
      busy = 1'b0;
      err = 1'b0;
      check("pkt_timeout", 32'(fin), 32'd1);
   endtask

   int n22;

   initial begin
      repeat (2) tick();
      check("rst_pkt_valid", 32'(pkt_valid), 0);
      check("rst_data_in",   32'(data_in),   0);
      check("rst_tx_active", 32'(tx_active), 0);
      check("rst_flags",     32'({done, pkt_err, req_err, ld_ovf}), 0);
      reset_n = 1'b1;
      tick();

      // Basic 3-byte packet to port 1.
      load(8'h11); load(8'h22); load(8'h33);
      pulse_start(2'd1);
      run_pkt(1'b0, 8'h00, 1'b0);
      check("p1_len", 32'(lg.size()), 7);
      if (lg.size() == 7) begin
         check("p1_hdr", 32'(lg[0]), 'h10D);
         check("p1_b0",  32'(lg[1]), 'h111);
         check("p1_b1",  32'(lg[2]), 'h122);
         check("p1_b2",  32'(lg[3]), 'h133);
         check("p1_par", 32'(lg[4]), 'h00D);
         check("p1_chk", 32'({lg[5], lg[6]}), 0);
      end
      check("p1_done", 32'(done_seen), 1);

      // Same packet with backpressure on byte 0x22.
      load(8'h11); load(8'h22); load(8'h33);
      pulse_start(2'd1);
      run_pkt(1'b1, 8'h22, 1'b0);
      n22 = 0;
      foreach (lg[i]) if (lg[i] == 9'h122) n22++;
      check("p2_hold_cycles", 32'(n22), 5);
      check("p2_len", 32'(lg.size()), 11);
      if (lg.size() == 11) check("p2_par", 32'(lg[8]), 'h00D);
      check("p2_done", 32'(done_seen), 1);

      // Rejected starts: empty buffer, then invalid destination.
      pulse_start(2'd1);
      check("rej_empty_req_err", 32'(req_err), 1);
      check("rej_empty_pv", 32'(pkt_valid), 0);
      tick();
      check("rej_pulse_len", 32'(req_err), 0);
      load(8'hA5); load(8'h5A);
      pulse_start(2'd3);
      check("rej_addr_req_err", 32'(req_err), 1);
      check("rej_addr_active", 32'(tx_active), 0);
      pulse_start(2'd2);
      run_pkt(1'b0, 8'h00, 1'b0);
      check("kept_len", 32'(lg.size()), 6);
      if (lg.size() == 6) begin
         check("kept_hdr", 32'(lg[0]), 'h10A);
         check("kept_par", 32'(lg[3]), 'h0F5);
      end

      // Overflow: 64 loads into a 63-byte buffer; parity error in second check cycle.
      for (int i = 1; i <= 64; i++) load(8'(i));
      check("ovf_flag", 32'(ld_ovf), 1);
      pulse_start(2'd0);
      check("ovf_cleared", 32'(ld_ovf), 0);
      check("ovf_hdr", 32'(data_in), 'hFC);
      run_pkt(1'b0, 8'h00, 1'b1);
      check("ovf_len", 32'(lg.size()), 67);
      if (lg.size() == 67) check("ovf_par", 32'(lg[64]), 'h0FC);
      check("ovf_done", 32'(done_seen), 1);
      check("ovf_pkt_err", 32'(pkt_err), 1);

      // Single-byte packet; accepted start clears pkt_err.
      load(8'h5A);
      pulse_start(2'd2);
      check("one_pkt_err_clr", 32'(pkt_err), 0);
      run_pkt(1'b0, 8'h00, 1'b0);
      check("one_len", 32'(lg.size()), 5);
      if (lg.size() == 5) begin
         check("one_hdr", 32'(lg[0]), 'h106);
         check("one_b0",  32'(lg[1]), 'h15A);
         check("one_par", 32'(lg[2]), 'h05C);
      end

      // Abort while the fifth payload byte is presented.
      for (int i = 0; i < 8; i++) load(8'(8'h40 + i));
      pulse_start(2'd1);
      repeat (5) tick();
      check("abt_byte5", 32'({pkt_valid, data_in}), 'h144);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abt_pv", 32'(pkt_valid), 0);
      check("abt_active", 32'(tx_active), 0);
      check("abt_data", 32'(data_in), 0);
      check("abt_no_done", 32'(done), 0);
      repeat (3) tick();
      pulse_start(2'd1);
      check("abt_count_clr", 32'(req_err), 1);

      // Asynchronous reset while the header is presented.
      load(8'h77); load(8'h88);
      pulse_start(2'd0);
      check("rstm_hdr", 32'({pkt_valid, data_in}), 'h108);
      #2 reset_n = 1'b0;
      #1;
      check("rstm_pv", 32'(pkt_valid), 0);
      check("rstm_data", 32'(data_in), 0);
      check("rstm_active", 32'(tx_active), 0);
      check("rstm_flags", 32'({done, pkt_err, req_err, ld_ovf}), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      pulse_start(2'd0);
      check("rstm_count_clr", 32'(req_err), 1);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
